// File: rtl/rtc_bus_sched.sv
// Arbitrates display-refresh reads and user-edit writes onto a multiplexed RTC address/data bus.
// Optional fair arbitration is enabled with RTC_SCHED_FAIR_EN; otherwise writes take priority.
module rtc_bus_sched #(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic [7:0] rd_addr,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       rd_done,
  output logic [7:0] rd_data,
  output logic       wr_done,
  output logic       busy,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ale,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  // state   | meaning
  // IDLE    | bus released, waiting for a request
  // ADDR    | address driven, ale high
  // HOLD    | address held after ale falls
  // DATA    | rd_n or wr_n strobe low
  // RECOVER | strobes high, bus turned around; done pulsed on entry
  typedef enum logic [2:0] {IDLE, ADDR, HOLD, DATA, RECOVER} state_t;

  localparam logic [3:0] PHASE_LOAD = 4'(PHASE_CYC - 1);

  state_t     state;
  logic [3:0] phase_cnt;
  logic       is_wr;
  logic [7:0] data_lat;
  logic       grant_wr;
  logic       phase_end;

  assign phase_end = (phase_cnt == 4'd0);

`ifdef RTC_SCHED_FAIR_EN
  // 1 = last accepted request was a write
  logic last_grant;

  always_comb begin
    grant_wr = wr_req;
    if (rd_req && wr_req) grant_wr = ~last_grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_grant <= 1'b1;
    else if (state == IDLE && (rd_req || wr_req))
      last_grant <= grant_wr;
  end
`else
  always_comb begin
    grant_wr = wr_req;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase_cnt <= 4'd0;
      is_wr     <= 1'b0;
      data_lat  <= 8'h00;
      cs_n      <= 1'b1;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      ale       <= 1'b0;
      ad_oe     <= 1'b0;
      ad_out    <= 8'h00;
      rd_data   <= 8'h00;
      rd_done   <= 1'b0;
      wr_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req || wr_req) begin
            state     <= ADDR;
            phase_cnt <= PHASE_LOAD;
            is_wr     <= grant_wr;
            data_lat  <= wr_data;
            cs_n      <= 1'b0;
            ale       <= 1'b1;
            ad_oe     <= 1'b1;
            ad_out    <= grant_wr ? wr_addr : rd_addr;
            busy      <= 1'b1;
          end
        end
        ADDR: begin
          if (phase_end) begin
            state     <= HOLD;
            phase_cnt <= PHASE_LOAD;
            ale       <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (phase_end) begin
            state     <= DATA;
            phase_cnt <= PHASE_LOAD;
            if (is_wr) begin
              wr_n   <= 1'b0;
              ad_out <= data_lat;
            end else begin
              rd_n  <= 1'b0;
              ad_oe <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        DATA: begin
          if (phase_end) begin
            state     <= RECOVER;
            phase_cnt <= PHASE_LOAD;
            cs_n      <= 1'b1;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out    <= 8'h00;
            if (is_wr) begin
              wr_done <= 1'b1;
            end else begin
              rd_done <= 1'b1;
              rd_data <= ad_in;
            end
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        RECOVER: begin
          if (phase_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            phase_cnt <= phase_cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rtc_bus_sched.md
RTC_BUS_SCHED -- requirements
Module: rtc_bus_sched

Interface
REQ-001 The module SHALL have parameter PHASE_CYC, default 4, giving clock cycles per bus phase (legal 1..15).
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port rd_req, input, 1 bit: read request from the display-refresh requester, held high until rd_done.
REQ-005 The module SHALL have port rd_addr, input, 8 bits: RTC register address for the read.
REQ-006 The module SHALL have port wr_req, input, 1 bit: write request from the user-edit requester, held high until wr_done.
REQ-007 The module SHALL have port wr_addr, input, 8 bits: RTC register address for the write.
REQ-008 The module SHALL have port wr_data, input, 8 bits: write data.
REQ-009 The module SHALL have port rd_done, output, 1 bit: one-cycle pulse marking read complete.
REQ-010 The module SHALL have port rd_data, output, 8 bits: registered read result.
REQ-011 The module SHALL have port wr_done, output, 1 bit: one-cycle pulse marking write complete.
REQ-012 The module SHALL have port busy, output, 1 bit: high while a transaction is in progress.
REQ-013 The module SHALL have port cs_n, output, 1 bit: RTC chip select, active-low.
REQ-014 The module SHALL have ports rd_n and wr_n, output, 1 bit each: RTC read and write strobes, active-low.
REQ-015 The module SHALL have port ale, output, 1 bit: address latch enable for the multiplexed address/data bus.
REQ-016 The module SHALL have ports ad_out (output, 8 bits), ad_oe (output, 1 bit) and ad_in (input, 8 bits): the split multiplexed bus, with the tristate buffer at top level.

Function
REQ-017 The FSM SHALL have states IDLE, ADDR, HOLD, DATA and RECOVER; every non-IDLE state lasts exactly PHASE_CYC cycles, timed by a 4-bit phase counter.
REQ-018 In IDLE, when a request is pending, the module SHALL grant one request, latch its address, data and direction, and enter ADDR on the next edge.
REQ-019 In ADDR: cs_n=0, ale=1, ad_oe=1, ad_out=latched address.
REQ-020 In HOLD: cs_n=0, ale=0, ad_oe=1, ad_out=latched address.
REQ-021 In DATA for a write: wr_n=0, ad_oe=1, ad_out=latched data. In DATA for a read: rd_n=0, ad_oe=0.
REQ-022 For a read, rd_data SHALL capture ad_in on the last DATA cycle; rd_data holds between reads.
REQ-023 In RECOVER all strobes SHALL be high and ad_oe=0; the matching done pulse is asserted in the first RECOVER cycle.
REQ-024 For a request accepted at edge N, the done pulse SHALL occur in cycle N+1+3*PHASE_CYC (N+13 at the default).
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 The module SHALL not accept a request during RECOVER; the earliest next acceptance is the first IDLE cycle.
REQ-027 wr_n and rd_n SHALL never be low simultaneously, and ale SHALL never be high while rd_n or wr_n is low.
REQ-028 A request deasserted before acceptance SHALL be ignored; request inputs are not sampled after acceptance.

Reset
REQ-029 While rst=0, the module SHALL set state=IDLE, cs_n=1, rd_n=1, wr_n=1, ale=0, ad_oe=0, ad_out=0, rd_data=0, rd_done=0, wr_done=0, busy=0, last-grant=WRITE.
REQ-030 A reset asserted mid-transaction SHALL release the bus immediately; no done pulse is issued for the aborted transaction.

Configuration
REQ-031 When RTC_SCHED_FAIR_EN is defined, simultaneous rd_req and wr_req SHALL be granted to the requester not granted last, and the last-grant register SHALL update at each acceptance.
REQ-032 When RTC_SCHED_FAIR_EN is undefined, wr_req SHALL always win over rd_req, and no last-grant register SHALL exist.

Verification
REQ-033 Single write, addr=0x21, data=0x45, PHASE_CYC=4: ale high for 4 cycles with ad_out=0x21, then wr_n low for 4 cycles with ad_out=0x45, and wr_done 13 cycles after acceptance.
REQ-034 Single read, addr=0x22, with ad_in driven to 0x59 during DATA: rd_n low for 4 cycles, ad_oe=0, rd_done at N+13, and rd_data=0x59.
REQ-035 rd_req and wr_req held together, with fair mode enabled: grants alternate read, write, read, with a first grant to read after reset; with fair mode disabled, all grants go to write while wr_req stays high.
REQ-036 rst pulled low during DATA of a write: cs_n, wr_n and ad_oe deassert within the same cycle, and no wr_done occurs.
REQ-037 Back-to-back reads held high: the next ADDR starts PHASE_CYC+1 cycles after rd_done, and a checker confirms REQ-027 holds throughout.
REQ-038 Sweep PHASE_CYC=1 and PHASE_CYC=15: done latency equals 1+3*PHASE_CYC in both cases.
